mmu_region_map: RTL and testbench

Parametrised, registered virtual-to-physical address translator for the data-memory path. It has NUM_REGIONS windows, each with its own base, size, growth direction and wait-state count. It uses a valid/ready request/response handshake with one outstanding access and per-region write strobes. It also records misses in a sticky fault register. It sits between the core's load/store unit and the data/stack/UART memories.

---
 rtl/mmu_pkg.sv | 16 +
 rtl/mmu_region_match.sv | 24 ++
 rtl/mmu_region_map.sv | 126 ++++++++++++
 tb/tb_mmu_region_map.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared FSM type and default region map for the data-memory MMU
package mmu_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;
    localparam logic [15:0] DATA_BASE    = 16'h0000;
    localparam logic [15:0] STACK_BASE   = 16'h0400;
    localparam logic [15:0] UART_BASE    = 16'h0800;
    localparam logic [15:0] BLOCK_SIZE   = 16'd64;
    localparam int          REGION_DATA  = 0;
    localparam int          REGION_STACK = 1;
    localparam int          REGION_UART  = 2;
    localparam int          WAIT_W       = 4;
endpackage

// File: rtl/mmu_region_match.sv
// mmu_region_match: combinational window test for one region, up- or down-growing
module mmu_region_match
    import mmu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] va,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] size,
    input  logic              down,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);
    logic [ADDR_W:0] va_x;
    logic [ADDR_W:0] base_x;
    logic [ADDR_W:0] size_x;
    assign va_x   = {1'b0, va};
    assign base_x = {1'b0, base};
    assign size_x = {1'b0, size};
    // one extra bit keeps base+size and va+size from wrapping, so windows clip at the address-space edges
    assign hit    = down ? (va_x <= base_x) && (va_x + size_x > base_x)
                         : (va_x >= base_x) && (va_x < base_x + size_x);
    assign offset = hit ? (down ? base - va : va - base) : '0;
endmodule

// File: rtl/mmu_region_map.sv
// mmu_region_map: registered virtual-to-physical translator with wait states and sticky fault capture
module mmu_region_map
    import mmu_pkg::*;
#(
    parameter int                            ADDR_W      = 16,
    parameter int                            NUM_REGIONS = 3,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {UART_BASE, STACK_BASE, DATA_BASE},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = {BLOCK_SIZE, BLOCK_SIZE, BLOCK_SIZE},
    parameter logic [NUM_REGIONS-1:0]        REGION_DOWN = 3'b010,
    parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd2, 4'd0, 4'd0},
    parameter int                            FCNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic                   req_we,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_hit,
    output logic [NUM_REGIONS-1:0] resp_region,
    output logic [ADDR_W-1:0]      resp_phys,
    output logic [NUM_REGIONS-1:0] wr_en,
    output logic                   fault_valid,
    output logic [ADDR_W-1:0]      fault_addr,
    output logic                   fault_we,
    output logic [FCNT_W-1:0]      fault_count,
    input  logic                   fault_clr
);
    state_t                   state;
    logic [WAIT_W-1:0]        cnt;
    logic                     we_q;
    logic [NUM_REGIONS-1:0]   hits;
    logic [ADDR_W-1:0]        offs [NUM_REGIONS];
    logic                     sel_hit;
    logic [NUM_REGIONS-1:0]   sel_region;
    logic [ADDR_W-1:0]        sel_phys;
    logic [WAIT_W-1:0]        sel_wait;
    logic                     accept;
    logic                     miss;

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_match
        mmu_region_match #(.ADDR_W(ADDR_W)) u_match (
            .va    (req_addr),
            .base  (REGION_BASE[i*ADDR_W +: ADDR_W]),
            .size  (REGION_SIZE[i*ADDR_W +: ADDR_W]),
            .down  (REGION_DOWN[i]),
            .hit   (hits[i]),
            .offset(offs[i])
        );
    end

    // priority select: scan from the top so the lowest matching index is written last and wins
    always_comb begin
        sel_hit    = 1'b0;
        sel_region = '0;
        sel_phys   = '0;
        sel_wait   = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                sel_hit       = 1'b1;
                sel_region    = '0;
                sel_region[i] = 1'b1;
                sel_phys      = offs[i];
                sel_wait      = REGION_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign req_ready  = rst_n && (state == S_IDLE || (state == S_RESP && resp_ready));
    assign accept     = req_valid && req_ready;
    assign miss       = accept && !sel_hit;
    assign resp_valid = (state == S_RESP);
    assign wr_en      = {NUM_REGIONS{resp_valid && resp_ready && we_q}} & resp_region;

    // request FSM: capture on accept, count wait states, hold the response until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            we_q        <= 1'b0;
            resp_hit    <= 1'b0;
            resp_region <= '0;
            resp_phys   <= '0;
        end else if (accept) begin
            we_q        <= req_we;
            resp_hit    <= sel_hit;
            resp_region <= sel_region;
            resp_phys   <= sel_phys;
            if (sel_hit && sel_wait != '0) begin
                state <= S_WAIT;
                cnt   <= sel_wait;
            end else begin
                state <= S_RESP;
            end
        end else if (state == S_WAIT) begin
            cnt <= cnt - WAIT_W'(1);
            if (cnt == WAIT_W'(1)) state <= S_RESP;
        end else if (state == S_RESP && resp_ready) begin
            state <= S_IDLE;
        end
    end

    // sticky fault record: first miss address is kept, count saturates; a miss beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_we    <= 1'b0;
            fault_count <= '0;
        end else if (miss) begin
            fault_valid <= 1'b1;
            if (!fault_valid || fault_clr) begin
                fault_addr <= req_addr;
                fault_we   <= req_we;
            end
            fault_count <= fault_clr ? FCNT_W'(1) : (&fault_count ? fault_count : fault_count + FCNT_W'(1));
        end else if (fault_clr) begin
            fault_valid <= 1'b0;
            fault_addr  <= '0;
            fault_we    <= 1'b0;
            fault_count <= '0;
        end
    end
endmodule

// File: tb/tb_mmu_region_map.sv
// tb_mmu_region_map: directed and randomized checks of the region translator against a range-based model
module tb_mmu_region_map;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic        resp_ready = 1'b0;
    logic        fault_clr = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_hit;
    logic [2:0]  resp_region;
    logic [15:0] resp_phys;
    logic [2:0]  wr_en;
    logic        fault_valid;
    logic [15:0] fault_addr;
    logic        fault_we;
    logic [7:0]  fault_count;

    int checks = 0;
    int errors = 0;

    int m_base [3] = '{'h0000, 'h0400, 'h0800};
    int m_size [3] = '{64, 64, 64};
    int m_down [3] = '{0, 1, 0};
    int m_wait [3] = '{0, 0, 2};

    logic        m_fv = 1'b0;
    logic [15:0] m_fa = '0;
    logic        m_fw = 1'b0;
    int          m_fc = 0;

    mmu_region_map dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_region(resp_region), .resp_phys(resp_phys), .wr_en(wr_en),
        .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_we(fault_we),
        .fault_count(fault_count), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    // reference: each window is an inclusive address range, first listed window that contains va wins
    function automatic void model(input int va, output logic h, output logic [2:0] r,
                                  output logic [15:0] p, output int lat);
        int lo;
        int hi;
        h = 1'b0; r = '0; p = '0; lat = 1;
        for (int i = 0; i < 3; i++) begin
            lo = m_down[i] != 0 ? m_base[i] - m_size[i] + 1 : m_base[i];
            hi = m_down[i] != 0 ? m_base[i] : m_base[i] + m_size[i] - 1;
            if (!h && va >= lo && va <= hi) begin
                h   = 1'b1;
                r   = 3'(1 << i);
                p   = 16'(m_down[i] != 0 ? m_base[i] - va : va - m_base[i]);
                lat = 1 + m_wait[i];
            end
        end
    endfunction

    function automatic void fault_model(input logic miss, input logic [15:0] va, input logic we, input logic clr);
        if (miss) begin
            if (!m_fv || clr) begin m_fa = va; m_fw = we; end
            m_fv = 1'b1;
            m_fc = clr ? 1 : (m_fc < 255 ? m_fc + 1 : 255);
        end else if (clr) begin
            m_fv = 1'b0; m_fa = '0; m_fw = 1'b0; m_fc = 0;
        end
    endfunction

    // one request from IDLE with resp_ready=1; reports latency and the response seen when resp_valid rises
    task automatic access(input logic [15:0] va, input logic we, input logic clr, output int lat,
                          output logic h, output logic [2:0] r, output logic [15:0] p,
                          output logic [2:0] w, output logic rdy_low);
        req_valid = 1'b1; req_addr = va; req_we = we; resp_ready = 1'b1; fault_clr = clr;
        @(posedge clk); #1;
        req_valid = 1'b0; fault_clr = 1'b0;
        lat = 1; rdy_low = 1'b1;
        while (!resp_valid && lat < 20) begin
            if (req_ready) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        h = resp_hit; r = resp_region; p = resp_phys; w = wr_en;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_region, resp_phys, wr_en, fault_valid, fault_addr, fault_we, fault_count} !== '0) begin
            errors++; $display("FAIL reset_outputs: got ready=%b valid=%b fv=%b cnt=%h, want all 0", req_ready, resp_valid, fault_valid, fault_count);
        end
        rst_n = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed_map();
        logic [15:0] d_va  [8] = '{16'h0010, 16'h0400, 16'h03C1, 16'h03C0, 16'h0401, 16'h0805, 16'h003F, 16'h083F};
        logic        d_we  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic        d_hit [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]  d_reg [8] = '{3'b001, 3'b010, 3'b010, 3'b000, 3'b000, 3'b100, 3'b001, 3'b100};
        logic [15:0] d_ph  [8] = '{16'h0010, 16'h0000, 16'h003F, 16'h0000, 16'h0000, 16'h0005, 16'h003F, 16'h003F};
        int          d_lat [8] = '{1, 1, 1, 1, 1, 3, 1, 3};
        logic [2:0]  d_wr  [8] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000};
        int lat; logic h; logic [2:0] r; logic [15:0] p; logic [2:0] w; logic rl;
        for (int k = 0; k < 8; k++) begin
            access(d_va[k], d_we[k], 1'b0, lat, h, r, p, w, rl);
            fault_model(!d_hit[k], d_va[k], d_we[k], 1'b0);
            checks++;
            if (h !== d_hit[k] || r !== d_reg[k] || p !== d_ph[k]) begin
                errors++; $display("FAIL dir_xlate[%h]: got hit=%b reg=%b phys=%h want hit=%b reg=%b phys=%h", d_va[k], h, r, p, d_hit[k], d_reg[k], d_ph[k]);
            end
            checks++;
            if (lat != d_lat[k] || rl !== 1'b1) begin
                errors++; $display("FAIL dir_latency[%h]: got %0d ready_low_in_wait=%b want %0d 1", d_va[k], lat, rl, d_lat[k]);
            end
            checks++;
            if (w !== d_wr[k] || wr_en !== 3'b000) begin
                errors++; $display("FAIL dir_wr_en[%h]: got %b then %b want %b then 000", d_va[k], w, wr_en, d_wr[k]);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic h; logic [2:0] r; logic [15:0] p; logic [2:0] w; logic rl;
        int e_lat; logic e_h; logic [2:0] e_r; logic [15:0] e_p;
        int va; logic we; logic clr; int win;
        for (int k = 0; k < 200; k++) begin
            win = int'($urandom_range(0, 3));
            va  = win == 3 ? int'($urandom_range(0, 65535)) : m_base[win] + int'($urandom_range(0, 140)) - 70;
            if (va < 0) va = 0;
            we  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0);
            access(16'(va), we, clr, lat, h, r, p, w, rl);
            model(va, e_h, e_r, e_p, e_lat);
            fault_model(!e_h, 16'(va), we, clr);
            checks++;
            if (h !== e_h || r !== e_r || p !== e_p || lat != e_lat || rl !== 1'b1) begin
                errors++; $display("FAIL rnd_xlate[%h]: got hit=%b reg=%b phys=%h lat=%0d want hit=%b reg=%b phys=%h lat=%0d", va, h, r, p, lat, e_h, e_r, e_p, e_lat);
            end
            checks++;
            if (w !== ((we && e_h) ? e_r : 3'b000)) begin
                errors++; $display("FAIL rnd_wr_en[%h]: got %b want %b", va, w, (we && e_h) ? e_r : 3'b000);
            end
            checks++;
            if (fault_valid !== m_fv || fault_addr !== m_fa || fault_we !== m_fw || fault_count !== 8'(m_fc)) begin
                errors++; $display("FAIL rnd_fault: got v=%b a=%h we=%b c=%0d want v=%b a=%h we=%b c=%0d", fault_valid, fault_addr, fault_we, fault_count, m_fv, m_fa, m_fw, m_fc);
            end
        end
    endtask

    task automatic test_faults();
        int lat; logic h; logic [2:0] r; logic [15:0] p; logic [2:0] w; logic rl;
        fault_clr = 1'b1; @(posedge clk); #1; fault_clr = 1'b0;
        fault_model(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({fault_valid, fault_addr, fault_we, fault_count} !== '0) begin
            errors++; $display("FAIL fault_clear: got v=%b a=%h c=%0d want 0", fault_valid, fault_addr, fault_count);
        end
        access(16'h0040, 1'b1, 1'b0, lat, h, r, p, w, rl);
        checks++;
        if (fault_valid !== 1'b1 || fault_addr !== 16'h0040 || fault_we !== 1'b1 || fault_count !== 8'd1 || h !== 1'b0) begin
            errors++; $display("FAIL fault_first: got v=%b a=%h we=%b c=%0d hit=%b want 1 0040 1 1 0", fault_valid, fault_addr, fault_we, fault_count, h);
        end
        access(16'h1000, 1'b0, 1'b0, lat, h, r, p, w, rl);
        checks++;
        if (fault_addr !== 16'h0040 || fault_we !== 1'b1 || fault_count !== 8'd2) begin
            errors++; $display("FAIL fault_sticky: got a=%h we=%b c=%0d want 0040 1 2", fault_addr, fault_we, fault_count);
        end
        access(16'h2000, 1'b0, 1'b1, lat, h, r, p, w, rl);
        checks++;
        if (fault_valid !== 1'b1 || fault_addr !== 16'h2000 || fault_we !== 1'b0 || fault_count !== 8'd1) begin
            errors++; $display("FAIL fault_clr_miss: got v=%b a=%h we=%b c=%0d want 1 2000 0 1", fault_valid, fault_addr, fault_we, fault_count);
        end
        for (int k = 0; k < 300; k++) access(16'($urandom_range(16'h1000, 16'hFFFF)), 1'b0, 1'b0, lat, h, r, p, w, rl);
        checks++;
        if (fault_count !== 8'hFF || fault_addr !== 16'h2000) begin
            errors++; $display("FAIL fault_saturate: got c=%h a=%h want FF 2000", fault_count, fault_addr);
        end
        fault_model(1'b1, 16'h2000, 1'b0, 1'b1);
        m_fc = 255;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a [4];
        for (int k = 0; k < 4; k++) a[k] = 16'($urandom_range(0, 63));
        req_valid = 1'b1; req_addr = 16'h0010; req_we = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr = a[0];
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_phys !== 16'h0010 || resp_region !== 3'b001 || req_ready !== 1'b0 || wr_en !== 3'b000) begin
                errors++; $display("FAIL hold[%0d]: got valid=%b phys=%h reg=%b ready=%b wr=%b want 1 0010 001 0 000", k, resp_valid, resp_phys, resp_region, req_ready, wr_en);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b1; #1;
        checks++;
        if (wr_en !== 3'b001 || req_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: got wr=%b ready=%b want 001 1", wr_en, req_ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_phys !== a[k] || wr_en !== 3'b001) begin
                errors++; $display("FAIL stream[%0d]: got valid=%b hit=%b phys=%h wr=%b want 1 1 %h 001", k, resp_valid, resp_hit, resp_phys, wr_en, a[k]);
            end
            if (k < 3) req_addr = a[k+1];
            else req_valid = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL stream_end: got valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat; logic h; logic [2:0] r; logic [15:0] p; logic [2:0] w; logic rl;
        access(16'h5000, 1'b1, 1'b0, lat, h, r, p, w, rl);
        req_valid = 1'b1; req_addr = 16'h0805; req_we = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || fault_valid !== 1'b1) begin
            errors++; $display("FAIL wait_state: got ready=%b valid=%b fv=%b want 0 0 1", req_ready, resp_valid, fault_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, resp_region, resp_phys, wr_en, fault_valid, fault_addr, fault_we, fault_count} !== '0) begin
            errors++; $display("FAIL async_reset: got ready=%b valid=%b fv=%b a=%h c=%0d want all 0", req_ready, resp_valid, fault_valid, fault_addr, fault_count);
        end
        #2 rst_n = 1'b1;
        fault_model(1'b0, 16'h0, 1'b0, 1'b1);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
        access(16'h0805, 1'b1, 1'b0, lat, h, r, p, w, rl);
        checks++;
        if (lat != 3 || h !== 1'b1 || r !== 3'b100 || p !== 16'h0005 || w !== 3'b100 || rl !== 1'b1) begin
            errors++; $display("FAIL post_reset_access: got lat=%0d hit=%b reg=%b phys=%h wr=%b want 3 1 100 0005 100", lat, h, r, p, w);
        end
    endtask

    initial begin
        test_reset();
        test_directed_map();
        test_random();
        test_faults();
        test_back_to_back();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
